// File: rtl/menu_select_ctrl_pkg.sv
// menu_pkg: button type codes, menu FSM states and index step helper shared with the drawing objects
package menu_pkg;
  localparam int MAX_BUTTONS = 8;
  typedef enum logic [2:0] {FREE = 3'b000, REGU = 3'b001, SLCT = 3'b010} button_type_t;
  typedef enum logic [2:0] {OFF, WAIT_RELEASE, READY, HOLD, LOCKED} menu_state_t;
  function automatic logic [2:0] step_idx(input logic [2:0] idx, input logic up, input int n, input bit wrap);
    logic [2:0] last;
    last = 3'(n - 1);
    if (up) return (idx == 3'd0) ? (wrap ? last : 3'd0) : idx - 3'd1;
    return (idx == last) ? (wrap ? 3'd0 : last) : idx + 3'd1;
  endfunction
endpackage

// File: rtl/menu_select_ctrl_if.sv
// menu_select_ctrl_if: keyboard/frame inputs and button-type/choice outputs of the menu controller
interface menu_select_ctrl_if #(parameter int NUM_BUTTONS = 4);
  logic startOfFrame;
  logic menu_active;
  logic key_up;
  logic key_down;
  logic key_enter;
  logic [3*NUM_BUTTONS-1:0] button_type_vec;
  logic [2:0] selected_idx;
  logic choice_valid;
  logic [2:0] choice_idx;
  modport master (
    output startOfFrame, menu_active, key_up, key_down, key_enter,
    input button_type_vec, selected_idx, choice_valid, choice_idx
  );
  modport slave (
    input startOfFrame, menu_active, key_up, key_down, key_enter,
    output button_type_vec, selected_idx, choice_valid, choice_idx
  );
endinterface

// File: rtl/menu_select_ctrl_key_edge_detect.sv
// key_edge_detect: one-cycle rise pulse from a key level using a delayed copy
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic rise
);
  logic key_d;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) key_d <= 1'b0;
    else key_d <= key;
  assign rise = key & ~key_d;
endmodule

// File: rtl/menu_select_ctrl.sv
// menu_select_ctrl: keyboard-driven menu selection with frame-paced auto-repeat and ENTER confirm
module menu_select_ctrl
  import menu_pkg::*;
#(
  parameter int NUM_BUTTONS   = 4,
  parameter int DEFAULT_IDX   = 0,
  parameter int HOLD_FRAMES   = 30,
  parameter int REPEAT_FRAMES = 8,
  parameter bit WRAP          = 1'b1
) (
  input logic clk,
  input logic resetN,
  menu_select_ctrl_if.slave bus
);
  localparam int CW = $clog2((HOLD_FRAMES > REPEAT_FRAMES ? HOLD_FRAMES : REPEAT_FRAMES) + 1);
  menu_state_t state, state_n;
  logic [2:0] sel, sel_n, ci, ci_n;
  logic [CW-1:0] cnt, cnt_n;
  logic dir, dir_n, cv, cv_n;
  logic [3*NUM_BUTTONS-1:0] btv, btv_n;
  logic rise_up, rise_down, rise_enter, any_key, released;
  key_edge_detect u_up    (.clk(clk), .resetN(resetN), .key(bus.key_up),    .rise(rise_up));
  key_edge_detect u_down  (.clk(clk), .resetN(resetN), .key(bus.key_down),  .rise(rise_down));
  key_edge_detect u_enter (.clk(clk), .resetN(resetN), .key(bus.key_enter), .rise(rise_enter));
  assign any_key  = bus.key_up | bus.key_down | bus.key_enter;
  // dir=1 means the HOLD was entered with key_up
  assign released = (dir ? ~bus.key_up : ~bus.key_down) | (bus.key_up & bus.key_down);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= OFF;
      sel   <= 3'(DEFAULT_IDX);
      cnt   <= '0;
      dir   <= 1'b0;
      cv    <= 1'b0;
      ci    <= 3'd0;
      btv   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
      cv    <= cv_n;
      ci    <= ci_n;
      btv   <= btv_n;
    end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    dir_n   = dir;
    cv_n    = 1'b0;
    ci_n    = ci;
    if (!bus.menu_active) state_n = OFF;
    else case (state)
      OFF: begin
        sel_n   = 3'(DEFAULT_IDX);
        state_n = any_key ? WAIT_RELEASE : READY;
      end
      WAIT_RELEASE: state_n = any_key ? WAIT_RELEASE : READY;
      READY:
        if (rise_enter) begin
          cv_n    = 1'b1;
          ci_n    = sel;
          state_n = LOCKED;
        end else if (rise_up ^ rise_down) begin
          sel_n   = step_idx(sel, rise_up, NUM_BUTTONS, WRAP);
          cnt_n   = CW'(HOLD_FRAMES);
          dir_n   = rise_up;
          state_n = HOLD;
        end
      HOLD:
        if (released) state_n = READY;
        else if (bus.startOfFrame) begin
          sel_n = (cnt == CW'(1)) ? step_idx(sel, dir, NUM_BUTTONS, WRAP) : sel;
          cnt_n = (cnt == CW'(1)) ? CW'(REPEAT_FRAMES) : cnt - CW'(1);
        end
      LOCKED: state_n = any_key ? LOCKED : READY;
      default: state_n = OFF;
    endcase
  end
  always_comb begin
    btv_n = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      btv_n[3*i +: 3] = (state == OFF) ? FREE : (sel == 3'(i)) ? SLCT : REGU;
  end
  assign bus.button_type_vec = btv;
  assign bus.selected_idx    = sel;
  assign bus.choice_valid    = cv;
  assign bus.choice_idx      = ci;
endmodule

// File: tb/tb_menu_select_ctrl.sv
// tb_menu_select_ctrl: directed checks of selection, auto-repeat, wrap/saturate, confirm and menu exit
module tb_menu_select_ctrl;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  menu_select_ctrl_if #(.NUM_BUTTONS(4)) bus ();
  menu_select_ctrl_if #(.NUM_BUTTONS(4)) bus0 ();
  assign bus0.startOfFrame = bus.startOfFrame;
  assign bus0.menu_active  = bus.menu_active;
  assign bus0.key_up       = bus.key_up;
  assign bus0.key_down     = bus.key_down;
  assign bus0.key_enter    = bus.key_enter;
  menu_select_ctrl #(.NUM_BUTTONS(4), .DEFAULT_IDX(0), .HOLD_FRAMES(30), .REPEAT_FRAMES(8), .WRAP(1'b1))
    dut (.clk(clk), .resetN(resetN), .bus(bus));
  menu_select_ctrl #(.NUM_BUTTONS(4), .DEFAULT_IDX(0), .HOLD_FRAMES(30), .REPEAT_FRAMES(8), .WRAP(1'b0))
    dut0 (.clk(clk), .resetN(resetN), .bus(bus0));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      tick();
    end
  endtask
  task automatic tap_down();
    bus.key_down = 1'b1;
    tick();
    bus.key_down = 1'b0;
    tick();
    tick();
  endtask
  task automatic test_reset();
    bus.startOfFrame = 1'b0;
    bus.menu_active = 1'b0;
    bus.key_up = 1'b0;
    bus.key_down = 1'b0;
    bus.key_enter = 1'b0;
    resetN = 1'b0;
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd0 || bus.button_type_vec !== 12'h000 || bus.choice_valid !== 1'b0 || bus.choice_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL reset: idx=%0d btv=%b cv=%b ci=%0d, want 0 000000000000 0 0", bus.selected_idx, bus.button_type_vec, bus.choice_valid, bus.choice_idx);
    end
    resetN = 1'b1;
    tick();
  endtask
  task automatic test_enter_menu();
    bus.menu_active = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd0 || bus.button_type_vec !== 12'b001_001_001_010) begin
      miscompares++;
      $display("FAIL enter_menu: idx=%0d btv=%b, want 0 001001001010", bus.selected_idx, bus.button_type_vec);
    end
  endtask
  task automatic test_short_press();
    bus.key_down = 1'b1;
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd1 || bus.button_type_vec !== 12'b001_001_001_010) begin
      miscompares++;
      $display("FAIL short_press_n1: idx=%0d btv=%b, want 1 001001001010", bus.selected_idx, bus.button_type_vec);
    end
    tick();
    vectors++;
    if (bus.button_type_vec !== 12'b001_001_010_001) begin
      miscompares++;
      $display("FAIL short_press_n2: btv=%b, want 001001010001", bus.button_type_vec);
    end
    tick();
    bus.key_down = 1'b0;
    tick();
    frames(40);
    vectors++;
    if (bus.selected_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL short_press_norepeat: idx=%0d, want 1", bus.selected_idx);
    end
    bus.key_up = 1'b1;
    tick();
    bus.key_up = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd0 || bus0.selected_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL short_press_up: idx=%0d idx0=%0d, want 0 0", bus.selected_idx, bus0.selected_idx);
    end
  endtask
  task automatic test_hold_repeat();
    bus.key_down = 1'b1;
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL hold_press: idx=%0d, want 1", bus.selected_idx);
    end
    frames(29);
    vectors++;
    if (bus.selected_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL hold_29: idx=%0d, want 1", bus.selected_idx);
    end
    frames(1);
    vectors++;
    if (bus.selected_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL hold_30: idx=%0d, want 2", bus.selected_idx);
    end
    frames(7);
    vectors++;
    if (bus.selected_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL hold_37: idx=%0d, want 2", bus.selected_idx);
    end
    frames(1);
    vectors++;
    if (bus.selected_idx !== 3'd3) begin
      miscompares++;
      $display("FAIL hold_38: idx=%0d, want 3", bus.selected_idx);
    end
    frames(8);
    vectors++;
    if (bus.selected_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL hold_46_wrap: idx=%0d, want 0", bus.selected_idx);
    end
    vectors++;
    if (bus0.selected_idx !== 3'd3 || bus0.button_type_vec !== 12'b010_001_001_001) begin
      miscompares++;
      $display("FAIL nowrap_saturate: idx=%0d btv=%b, want 3 010001001001", bus0.selected_idx, bus0.button_type_vec);
    end
    bus.key_down = 1'b0;
    tick();
    tick();
    bus.key_down = 1'b1;
    tick();
    bus.key_down = 1'b0;
    tick();
    vectors++;
    if (bus0.selected_idx !== 3'd3) begin
      miscompares++;
      $display("FAIL nowrap_press: idx=%0d, want 3", bus0.selected_idx);
    end
    tick();
  endtask
  task automatic test_enter_confirm();
    vectors++;
    if (bus.selected_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL confirm_pre: idx=%0d, want 1", bus.selected_idx);
    end
    tap_down();
    bus.key_enter = 1'b1;
    tick();
    vectors++;
    if (bus.choice_valid !== 1'b1 || bus.choice_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL confirm_pulse: cv=%b ci=%0d, want 1 2", bus.choice_valid, bus.choice_idx);
    end
    tick();
    vectors++;
    if (bus.choice_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL confirm_one_cycle: cv=%b, want 0", bus.choice_valid);
    end
    bus.key_down = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd2 || bus.choice_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL locked_no_move: idx=%0d cv=%b, want 2 0", bus.selected_idx, bus.choice_valid);
    end
    bus.key_down = 1'b0;
    bus.key_enter = 1'b0;
    tick();
    tick();
    bus.key_enter = 1'b1;
    tick();
    vectors++;
    if (bus.choice_valid !== 1'b1 || bus.choice_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL reconfirm: cv=%b ci=%0d, want 1 2", bus.choice_valid, bus.choice_idx);
    end
    bus.key_enter = 1'b0;
    tick();
    tick();
  endtask
  task automatic test_menu_exit();
    bus.menu_active = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.button_type_vec !== 12'h000) begin
      miscompares++;
      $display("FAIL exit_free: btv=%b, want 000000000000", bus.button_type_vec);
    end
    bus.key_up = 1'b1;
    bus.menu_active = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd0 || bus.button_type_vec !== 12'b001_001_001_010) begin
      miscompares++;
      $display("FAIL wait_release: idx=%0d btv=%b, want 0 001001001010", bus.selected_idx, bus.button_type_vec);
    end
    bus.key_up = 1'b0;
    tick();
    bus.key_up = 1'b1;
    tick();
    vectors++;
    if (bus.selected_idx !== 3'd3) begin
      miscompares++;
      $display("FAIL after_release_up: idx=%0d, want 3", bus.selected_idx);
    end
    frames(3);
    bus.menu_active = 1'b0;
    tick();
    vectors++;
    if (bus.choice_valid !== 1'b0 || bus.choice_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL exit_hold_choice: cv=%b ci=%0d, want 0 2", bus.choice_valid, bus.choice_idx);
    end
    tick();
    vectors++;
    if (bus.button_type_vec !== 12'h000 || bus.choice_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL exit_hold_free: btv=%b cv=%b, want 000000000000 0", bus.button_type_vec, bus.choice_valid);
    end
    bus.key_up = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_enter_menu();
    test_short_press();
    test_hold_repeat();
    test_enter_confirm();
    test_menu_exit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
